// File: rtl/h_u_serial_rsb12_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master supplies operands and result acceptance; the slave returns the difference.
interface h_u_serial_rsb12_if #(parameter int N = 12);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/h_u_serial_rsb12.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, N RUN cycles per pair.
// Result {borrow, a-b mod 2^N} is held in DONE until out_ready; no new operands accepted meanwhile.
module h_u_serial_rsb12 #(
  parameter int N = 12
) (
  input logic               clk,
  input logic               rst_n,
  h_u_serial_rsb12_if.slave bus
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_sd;
  logic          r_bw;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_out;

  logic          w_x;
  logic          w_y;
  logic          w_d;
  logic          w_bw_nxt;
  logic [N-1:0]  w_sd_nxt;
  logic          w_accept;
  logic          w_last;
  logic          w_in_ready;
  logic          w_out_valid;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_d      = w_x ^ w_y ^ r_bw;
  assign w_bw_nxt = (~w_x & w_y) | (~(w_x ^ w_y) & r_bw);
  // Shift-in at the MSB written without a part-select so N = 1 stays legal.
  assign w_sd_nxt = (r_sd >> 1) | (N'(w_d) << (N - 1));
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE:    w_in_ready  = 1'b1;
      DONE:    w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // The result register updates only on the final RUN edge, so out holds outside DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_sd  <= '0;
      r_bw  <= 1'b0;
      r_cnt <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_sa  <= bus.a;
      r_sb  <= bus.b;
      r_sd  <= '0;
      r_bw  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sd  <= w_sd_nxt;
      r_bw  <= w_bw_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_out <= {w_bw_nxt, w_sd_nxt};
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_out;

endmodule

// File: tb/tb_h_u_serial_rsb12.sv
// Bench for h_u_serial_rsb12: directed vector table, hand sequences, random stream and N=1/N=5 sweeps.
// Expected results come from a plain-arithmetic reference of {a < b, a - b mod 2^N}.
module tb_h_u_serial_rsb12;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  h_u_serial_rsb12_if #(.N(12)) bus12 ();
  h_u_serial_rsb12_if #(.N(5))  bus5 ();
  h_u_serial_rsb12_if #(.N(1))  bus1 ();

  h_u_serial_rsb12 #(.N(12)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus12));
  h_u_serial_rsb12 #(.N(5))  dut_5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  h_u_serial_rsb12 #(.N(1))  dut_1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [12:0] exp;
  } vec_t;

  vec_t vt[6];

  function automatic logic [31:0] ref_sub(input int unsigned a, input int unsigned b, input int n);
    int unsigned m;
    m = 32'd1 << n;
    if (a >= b) return a - b;
    return m + (m + a - b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a pair, waits for acceptance and the result, then completes the output handshake.
  task automatic do_op12(input logic [11:0] a, input logic [11:0] b, input bit hold, input bit throttle,
                         output logic [12:0] res, output int lat, output int acc);
    int  w;
    bit  r;
    bus12.a = a;
    bus12.b = b;
    bus12.in_valid = 1'b1;
    w = 0;
    while (!bus12.in_ready && w < 100) begin step(); w++; end
    if (!bus12.in_ready) check("accept_timeout", 32'(bus12.in_ready), 32'd1);
    step();
    acc = cyc;
    if (!hold) bus12.in_valid = 1'b0;
    bus12.a = 12'($urandom);
    bus12.b = 12'($urandom);
    lat = 0;
    while (!bus12.out_valid && lat < 100) begin step(); lat++; end
    res = bus12.out;
    w = 0;
    do begin
      bus12.out_ready = (throttle && w < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
      r = bus12.out_ready;
      step();
      w++;
      if (!r) begin
        check("bp_out_hold", 32'(bus12.out), 32'(res));
        check("bp_vld_hold", 32'(bus12.out_valid), 32'd1);
        check("bp_rdy_low", 32'(bus12.in_ready), 32'd0);
      end
    end while (!r);
  endtask

  logic [12:0] res;
  logic [12:0] sum;
  logic [5:0]  res5;
  logic [1:0]  res1;
  int          lat;
  int          acc;
  int          prev_acc;
  int          w;
  logic [11:0] ra;
  logic [11:0] rb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{a: 12'd100,   b: 12'd7,     exp: 13'd93};
    vt[1] = '{a: 12'd5,     b: 12'd9,     exp: 13'd8188};
    vt[2] = '{a: 12'd0,     b: 12'd1,     exp: 13'd8191};
    vt[3] = '{a: 12'hFFF,   b: 12'hFFF,   exp: 13'd0};
    vt[4] = '{a: 12'd4095,  b: 12'd0,     exp: 13'd4095};
    vt[5] = '{a: 12'd0,     b: 12'd4095,  exp: 13'd4097};

    bus12.in_valid = 1'b0; bus12.a = '0; bus12.b = '0; bus12.out_ready = 1'b1;
    bus5.in_valid  = 1'b0; bus5.a  = '0; bus5.b  = '0; bus5.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.out_ready  = 1'b1;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus12.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus12.out_valid), 32'd0);
    check("rst_out", 32'(bus12.out), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      do_op12(vt[i].a, vt[i].b, 1'b0, 1'b0, res, lat, acc);
      check("vec_out", 32'(res), 32'(vt[i].exp));
      check("vec_latency", 32'(lat), 32'd12);
      check("vec_vld_drop", 32'(bus12.out_valid), 32'd0);
      check("vec_rdy_back", 32'(bus12.in_ready), 32'd1);
    end

    // Backpressure with in_valid toggling and operands churning while DONE is held.
    bus12.a = 12'd3000; bus12.b = 12'd1000; bus12.in_valid = 1'b1; bus12.out_ready = 1'b0;
    w = 0;
    while (!bus12.in_ready && w < 100) begin step(); w++; end
    step();
    bus12.in_valid = 1'b0;
    lat = 0;
    while (!bus12.out_valid && lat < 100) begin step(); lat++; end
    check("bp_latency", 32'(lat), 32'd12);
    for (int k = 0; k < 5; k++) begin
      bus12.in_valid = ~bus12.in_valid;
      bus12.a = 12'($urandom);
      bus12.b = 12'($urandom);
      check("bp_out", 32'(bus12.out), 32'd2000);
      check("bp_out_valid", 32'(bus12.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus12.in_ready), 32'd0);
      step();
    end
    check("bp_out_end", 32'(bus12.out), 32'd2000);
    bus12.a = 12'd50; bus12.b = 12'd20; bus12.in_valid = 1'b1; bus12.out_ready = 1'b1;
    step();
    check("bp_release_vld", 32'(bus12.out_valid), 32'd0);
    check("bp_release_rdy", 32'(bus12.in_ready), 32'd1);
    step();
    bus12.in_valid = 1'b0;
    check("bp_next_busy", 32'(bus12.in_ready), 32'd0);
    lat = 0;
    while (!bus12.out_valid && lat < 100) begin step(); lat++; end
    check("bp_next_out", 32'(bus12.out), 32'd30);
    check("bp_next_latency", 32'(lat), 32'd12);
    step();

    // Reset during the 6th RUN cycle.
    bus12.a = 12'd1234; bus12.b = 12'd1; bus12.in_valid = 1'b1;
    w = 0;
    while (!bus12.in_ready && w < 100) begin step(); w++; end
    step();
    bus12.in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus12.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus12.out), 32'd0);
    check("mid_rst_rdy", 32'(bus12.in_ready), 32'd1);
    #2 rst_n = 1'b1;
    step();
    do_op12(12'd4095, 12'd2048, 1'b0, 1'b0, res, lat, acc);
    check("post_rst_out", 32'(res), 32'd2047);
    check("post_rst_latency", 32'(lat), 32'd12);

    // Random stream: in_valid held high, out_ready randomly throttled.
    prev_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      do_op12(ra, rb, 1'b1, 1'b1, res, lat, acc);
      check("rand_out", 32'(res), ref_sub(32'(ra), 32'(rb), 12));
      check("rand_latency", 32'(lat), 32'd12);
      sum = {1'b0, res[11:0]} + {1'b0, rb};
      check("rand_adder_a", 32'(sum[11:0]), 32'(ra));
      check("rand_adder_carry", 32'(sum[12]), 32'(res[12]));
      if (i > 0) check("rand_ii_ge_14", 32'(acc - prev_acc >= 14), 32'd1);
      prev_acc = acc;
    end
    bus12.in_valid = 1'b0;
    bus12.out_ready = 1'b1;
    step();
    step();

    for (int x = 0; x < 32; x++) begin
      for (int y = 0; y < 32; y++) begin
        bus5.a = 5'(x); bus5.b = 5'(y); bus5.in_valid = 1'b1;
        w = 0;
        while (!bus5.in_ready && w < 100) begin step(); w++; end
        step();
        bus5.in_valid = 1'b0;
        lat = 0;
        while (!bus5.out_valid && lat < 100) begin step(); lat++; end
        res5 = bus5.out;
        check("n5_out", 32'(res5), ref_sub(32'(x), 32'(y), 5));
        check("n5_latency", 32'(lat), 32'd5);
        step();
      end
    end

    for (int x = 0; x < 2; x++) begin
      for (int y = 0; y < 2; y++) begin
        bus1.a = 1'(x); bus1.b = 1'(y); bus1.in_valid = 1'b1;
        w = 0;
        while (!bus1.in_ready && w < 100) begin step(); w++; end
        step();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 100) begin step(); lat++; end
        res1 = bus1.out;
        check("n1_out", 32'(res1), ref_sub(32'(x), 32'(y), 1));
        check("n1_latency", 32'(lat), 32'd1);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
